ranges_seq: RTL and testbench
=============================

RANGES_SEQ -- requirements
Module: ranges_seq

Interface
REQ-001 Parameter N, default 8: anchor coordinate width, matching the intersection block's N.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 xP, yP  input  signed N+2  point coordinates, same width as the intersection outputs.
REQ-006 xK, yK, xL, yL  input  signed N  anchor K and anchor L coordinates.
REQ-007 rK, rL  output  signed N+1  ranges from P to K and from P to L, same width as the intersection radius inputs.
REQ-008 rK_ovf, rL_ovf  output  1  set when the corresponding range saturated.
REQ-009 busy  output  1  high while a computation is in progress.
REQ-010 valid  output  1  single-cycle result strobe.

Function
REQ-011 Block SHALL compute the inverse of circle intersection: rK = floor(sqrt((xP-xK)^2 + (yP-yK)^2)), and rL likewise with anchor L.
REQ-012 FSM SHALL have four states: IDLE, SQ, RT, DONE.
REQ-013 IDLE: on a rising edge with start=1, the block SHALL register xP, yP, xK, yK, xL, yL and go to SQ; start=0 keeps IDLE.
REQ-014 SQ (1 cycle):
- dx, dy SHALL be formed at N+3 bits signed, sign-extended.
- Sums dK = dx^2+dy^2 and dL SHALL be registered at 2N+5 bits unsigned, without truncation.
- Iteration counter SHALL load N+2; go to RT.
REQ-015 RT: one restoring square-root step per cycle for K and L in parallel; 2 radicand bits per step, MSB first; N+3 steps total. After the step with counter=0, go to DONE.
REQ-016 DONE (1 cycle):
- Root below 2^N: rK/rL SHALL take the root and ovf=0.
- Otherwise: output SHALL be 2^N-1 and ovf=1.
- valid SHALL be 1; next state is IDLE.
REQ-017 Latency: valid SHALL be high in the cycle after the (N+5)th rising edge following the edge that sampled start (13 edges for N=8).
REQ-018 busy SHALL be 1 in SQ and RT, and 0 in IDLE and DONE.
REQ-019 start SHALL be ignored in SQ, RT and DONE: no queuing, no restart.
REQ-020 Input changes after the start edge SHALL NOT affect the result in flight.
REQ-021 rK, rL, rK_ovf and rL_ovf SHALL hold their values until the next DONE.
REQ-022 The earliest a new start can be accepted is the first IDLE cycle after DONE, giving a throughput of one result per N+6 cycles.
REQ-023 Root computation SHALL be exact integer floor; no rounding.

Reset
REQ-024 While rst_n=0, independent of clk:
- state SHALL be IDLE;
- rK, rL, rK_ovf, rL_ovf, busy and valid SHALL be 0;
- the internal radicand, remainder and counter registers SHALL be 0.
REQ-025 Reset asserted in any state, including mid-RT, SHALL abort without a valid pulse; the first start after release SHALL begin a fresh computation.

Verification (N=8)
REQ-026 P=(3,4), K=(0,0), L=(6,8), one-cycle start -> valid at edge 13, rK=5, rL=5, both ovf=0, busy high for edges 1-12.
REQ-027 P=(0,0), K=(0,0), L=(-128,-128) -> rK=0, rL=181 (floor of 181.02), ovf=0.
REQ-028 P=(511,511), K=(-128,-128), L=(0,0) -> rK=255, rK_ovf=1 (true 903); rL=255, rL_ovf=1 (true 722).
REQ-029 Start held high continuously, inputs changed every cycle:
- results SHALL match the inputs sampled at each accepting edge;
- valid SHALL pulse every 14 cycles.
REQ-030 rst_n pulled low at RT step 5 -> outputs 0 immediately, no valid; restart with REQ-026 inputs after release -> rK=rL=5 after 13 edges.
REQ-031 Round trip:
- random anchors and radii drive the intersection block; each resulting point feeds ranges_seq;
- rK and rL SHALL lie within ±2 of the original radii, excluding degenerate and non-intersecting cases.

Source files
------------

// File: rtl/ranges_seq.sv
// ranges_seq: sequential range computation from a point P to two anchors K and L.
// Each range is floor(sqrt(dx^2 + dy^2)), computed with a restoring square root
// that retires two radicand bits per cycle for both anchors in parallel.
// Ranges that do not fit in N bits saturate to 2^N-1 and raise the ovf flag.
module ranges_seq #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N+1:0] xP,
  input  logic signed [N+1:0] yP,
  input  logic signed [N-1:0] xK,
  input  logic signed [N-1:0] yK,
  input  logic signed [N-1:0] xL,
  input  logic signed [N-1:0] yL,
  output logic signed [N:0]   rK,
  output logic signed [N:0]   rL,
  output logic                rK_ovf,
  output logic                rL_ovf,
  output logic                busy,
  output logic                valid
);

  // Difference width, radicand width (sum of squares padded to an even
  // number of bits), remainder width, root width, and step-counter width.
  localparam int DW    = N + 3;
  localparam int RADW  = 2 * DW;
  localparam int RMW   = N + 6;
  localparam int ROOTW = N + 3;
  localparam int CW    = $clog2(N + 3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    RT   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [N+1:0] xP_q, yP_q;
  logic signed [N-1:0] xK_q, yK_q, xL_q, yL_q;

  logic [RADW-1:0]  radK_q, radK_d, radL_q, radL_d;
  logic [RMW-1:0]   remK_q, remK_d, remL_q, remL_d;
  logic [ROOTW-1:0] rootK_q, rootK_d, rootL_q, rootL_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N:0] rK_q, rL_q;
  logic       rK_ovf_q, rL_ovf_q, valid_q;
  logic [N+1:0] satK, satL;

  // Sum of squared differences; the differences are sign-extended to N+3 bits
  // so the widest point/anchor spread cannot wrap. The result is always below
  // 2^(2N+5), so the top bit of the returned value is zero.
  function automatic logic [RADW-1:0] sum_sq(input logic signed [N+1:0] px,
                                             input logic signed [N+1:0] py,
                                             input logic signed [N-1:0] ax,
                                             input logic signed [N-1:0] ay);
    logic signed [DW-1:0]   dx, dy;
    logic signed [RADW-1:0] ex, ey;
    dx = DW'(px) - DW'(ax);
    dy = DW'(py) - DW'(ay);
    ex = RADW'(dx);
    ey = RADW'(dy);
    return RADW'(ex * ex + ey * ey);
  endfunction

  // One restoring square-root step: bring down the next radicand bit pair and
  // try to subtract 4*root+1. The remainder never exceeds 2*root, so the
  // trial value always fits in RMW bits.
  function automatic logic [RMW+ROOTW-1:0] sqrt_step(input logic [RMW-1:0]   rem,
                                                     input logic [ROOTW-1:0] root,
                                                     input logic [1:0]       pair);
    logic [RMW+1:0] trial, test;
    trial = {rem, pair};
    test  = (RMW+2)'({root, 2'b01});
    if (trial >= test) begin
      sqrt_step = {RMW'(trial - test), root[ROOTW-2:0], 1'b1};
    end else begin
      sqrt_step = {RMW'(trial), root[ROOTW-2:0], 1'b0};
    end
  endfunction

  // Clamp the root to N bits; returns {ovf, range}.
  function automatic logic [N+1:0] sat_root(input logic [ROOTW-1:0] root);
    if (root[ROOTW-1:N] != '0) begin
      sat_root = {1'b1, 1'b0, {N{1'b1}}};
    end else begin
      sat_root = {1'b0, root[N:0]};
    end
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SQ;
      SQ:      state_d = RT;
      RT:      if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == SQ) || (state_q == RT);
  end

  // Capture the operands on the accepting edge so later input changes cannot
  // disturb the computation in flight.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      xP_q <= xP;
      yP_q <= yP;
      xK_q <= xK;
      yK_q <= yK;
      xL_q <= xL;
      yL_q <= yL;
    end
  end

  // Square-root datapath next state: load radicands in SQ, iterate in RT.
  always_comb begin
    radK_d  = radK_q;
    radL_d  = radL_q;
    remK_d  = remK_q;
    remL_d  = remL_q;
    rootK_d = rootK_q;
    rootL_d = rootL_q;
    cnt_d   = cnt_q;
    case (state_q)
      SQ: begin
        radK_d  = sum_sq(xP_q, yP_q, xK_q, yK_q);
        radL_d  = sum_sq(xP_q, yP_q, xL_q, yL_q);
        remK_d  = '0;
        remL_d  = '0;
        rootK_d = '0;
        rootL_d = '0;
        cnt_d   = CW'(N + 2);
      end
      RT: begin
        {remK_d, rootK_d} = sqrt_step(remK_q, rootK_q, radK_q[RADW-1 -: 2]);
        {remL_d, rootL_d} = sqrt_step(remL_q, rootL_q, radL_q[RADW-1 -: 2]);
        radK_d = radK_q << 2;
        radL_d = radL_q << 2;
        cnt_d  = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Square-root datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radK_q  <= '0;
      radL_q  <= '0;
      remK_q  <= '0;
      remL_q  <= '0;
      rootK_q <= '0;
      rootL_q <= '0;
      cnt_q   <= '0;
    end else begin
      radK_q  <= radK_d;
      radL_q  <= radL_d;
      remK_q  <= remK_d;
      remL_q  <= remL_d;
      rootK_q <= rootK_d;
      rootL_q <= rootL_d;
      cnt_q   <= cnt_d;
    end
  end

  assign satK = sat_root(rootK_q);
  assign satL = sat_root(rootL_q);

  // Result registers: loaded when leaving DONE and held until the next DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rK_q     <= '0;
      rL_q     <= '0;
      rK_ovf_q <= 1'b0;
      rL_ovf_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        {rK_ovf_q, rK_q} <= satK;
        {rL_ovf_q, rL_q} <= satL;
      end
    end
  end

  assign rK     = rK_q;
  assign rL     = rL_q;
  assign rK_ovf = rK_ovf_q;
  assign rL_ovf = rL_ovf_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_ranges_seq.sv
// Testbench for ranges_seq (N=8): directed and random ranges checked through a
// scoreboard of expected results, including latency, saturation, back-to-back
// starts and reset in the middle of a computation.
module tb_ranges_seq;
  localparam int N   = 8;
  localparam int LAT = N + 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic signed [N+1:0] xP, yP;
  logic signed [N-1:0] xK, yK, xL, yL;
  logic signed [N:0]   rK, rL;
  logic                rK_ovf, rL_ovf, busy, valid;

  typedef struct {
    logic [N:0] rk;
    logic [N:0] rl;
    logic       ok;
    logic       ol;
    int         due;
  } exp_t;

  exp_t sbq[$];
  exp_t last;
  exp_t mon_e;
  int   nchecks = 0;
  int   nerr    = 0;
  int   cyc     = 0;

  ranges_seq #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .xP     (xP),
    .yP     (yP),
    .xK     (xK),
    .yK     (yK),
    .xL     (xL),
    .yL     (yL),
    .rK     (rK),
    .rL     (rL),
    .rK_ovf (rK_ovf),
    .rL_ovf (rL_ovf),
    .busy   (busy),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference range: integer floor square root by upward search, then clamp.
  task automatic model(input int px, input int py, input int ax, input int ay,
                       output logic [N:0] r, output logic o);
    longint dx, dy, d, s;
    dx = longint'(px) - longint'(ax);
    dy = longint'(py) - longint'(ay);
    d  = dx * dx + dy * dy;
    s  = 0;
    while ((s + 1) * (s + 1) <= d) s++;
    if (s > (2 ** N) - 1) begin
      r = (N+1)'((2 ** N) - 1);
      o = 1'b1;
    end else begin
      r = (N+1)'(s);
      o = 1'b0;
    end
  endtask

  task automatic push(input int px, input int py, input int kx, input int ky,
                      input int lx, input int ly);
    exp_t e;
    model(px, py, kx, ky, e.rk, e.ok);
    model(px, py, lx, ly, e.rl, e.ol);
    e.due = cyc + LAT;
    sbq.push_back(e);
  endtask

  task automatic set_inputs(input int px, input int py, input int kx, input int ky,
                            input int lx, input int ly);
    xP = 10'(px);
    yP = 10'(py);
    xK = 8'(kx);
    yK = 8'(ky);
    xL = 8'(lx);
    yL = 8'(ly);
  endtask

  task automatic scramble();
    set_inputs(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  // One-cycle start pulse; returns just after the accepting edge with the
  // inputs already scrambled so the result must come from the captured values.
  task automatic drive(input int px, input int py, input int kx, input int ky,
                       input int lx, input int ly);
    @(negedge clk);
    set_inputs(px, py, kx, ky, lx, ly);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
  endtask

  task automatic do_run(input int px, input int py, input int kx, input int ky,
                        input int lx, input int ly);
    drive(px, py, kx, ky, lx, ly);
    push(px, py, kx, ky, lx, ly);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    nchecks++;
    assert (sbq.size() == 0) else begin
      nerr++;
      $error("FAIL %s: %0d results still outstanding, expected 0", tag, sbq.size());
    end
  endtask

  task automatic check_hold(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_rK"}, rK, last.rk);
    check({tag, "_rL"}, rL, last.rl);
    check({tag, "_ovf"}, {rK_ovf, rL_ovf}, {last.ok, last.ol});
  endtask

  // Scoreboard: every valid pulse must match the oldest expectation, in its
  // due cycle; a missing pulse is reported once its due cycle has passed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        nchecks++;
        assert (sbq.size() != 0) else begin
          nerr++;
          $error("FAIL unexpected_valid: observed valid at cycle %0d expected none", cyc);
        end
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("valid_cycle", cyc, mon_e.due);
          check("rK", rK, mon_e.rk);
          check("rL", rL, mon_e.rl);
          check("rK_ovf", rK_ovf, mon_e.ok);
          check("rL_ovf", rL_ovf, mon_e.ol);
          last = mon_e;
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
        nchecks++;
        nerr++;
        $error("FAIL missing_valid: observed no valid by cycle %0d expected at %0d", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_rK", rK, 0);
    check("reset_rL", rL, 0);
    check("reset_ovf", {rK_ovf, rL_ovf}, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    rst_n = 1'b1;

    // Basic 3-4-5 case with busy profile.
    do_run(3, 4, 0, 0, 6, 8);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("busy_high", busy, 1);
    end
    @(negedge clk);
    check("busy_done", busy, 0);
    check("valid_early", valid, 0);
    wait_done("run_345");
    check_hold("hold_345");

    // Zero range and a non-integer root.
    do_run(0, 0, 0, 0, -128, -128);
    wait_done("run_zero");

    // Both ranges saturate.
    do_run(511, 511, -128, -128, 0, 0);
    wait_done("run_sat");
    check_hold("hold_sat");

    // Extreme negative corner against positive anchors.
    do_run(-512, -512, 127, 127, -128, 127);
    wait_done("run_corner");

    // Start held high with inputs changing every cycle: accepted every 14 edges.
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      scramble();
      start = 1'b1;
      @(posedge clk);
      #1;
      if (k % 14 == 0) push(int'(xP), int'(yP), int'(xK), int'(yK), int'(xL), int'(yL));
    end
    start = 1'b0;
    wait_done("run_b2b");

    // Reset in the middle of the root iteration.
    drive(3, 4, 0, 0, 6, 8);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rK", rK, 0);
    check("midrst_rL", rL, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    do_run(3, 4, 0, 0, 6, 8);
    wait_done("run_after_rst");

    // Random points and anchors.
    for (int k = 0; k < 10; k++) begin
      int px, py, kx, ky, lx, ly;
      px = int'($urandom_range(0, 600)) - 300;
      py = int'($urandom_range(0, 600)) - 300;
      kx = int'($urandom_range(0, 255)) - 128;
      ky = int'($urandom_range(0, 255)) - 128;
      lx = int'($urandom_range(0, 255)) - 128;
      ly = int'($urandom_range(0, 255)) - 128;
      do_run(px, py, kx, ky, lx, ly);
      wait_done("run_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
